cpt_run_ctrl: RTL
=================

// Module: cpt_run_ctrl
// PURPOSE
//   Run controller and prescaler sitting directly upstream of cpt_bin8.
//   Generates the counter's 'activate' enable at a programmable rate and
//   sequences run/stop/single-step. Watches the counter value and halts
//   exactly at a programmed limit, so the counter never overshoots.
// PARAMETERS
//   WIDTH  8  counter width; must match the driven counter
//   DIV_W  8  prescaler divisor width
// PORTS
//   clk       in   1        system clock, rising edge
//   reset     in   1        asynchronous, active-low reset
//   start     in   1        run request, sampled each clk
//   stop      in   1        stop request, sampled each clk
//   step      in   1        single-increment request, sampled each clk
//   div       in   DIV_W    prescale: one activate pulse every div+1 clks
//   limit     in   WIDTH    terminal count at which the run halts
//   cpt       in   WIDTH    current counter value, fed back from counter
//   activate  out  1        registered enable to counter, 1-clk pulses
//   busy      out  1        1 in RUN or STEP
//   done      out  1        1 in DONE
// BEHAVIOUR
//   - Reset (reset=0): state=IDLE; pre=0; activate=0, busy=0, done=0,
//     asynchronously. Reset mid-run aborts with no further pulse.
//   - All outputs are registered and change only on the rising clk edge.
//   - States: IDLE, RUN, STEP, DONE. Command priority: stop > start > step.
//   - nxt = cpt + activate (mod 2^WIDTH) is the value the counter holds
//     after the current edge. All limit checks use nxt, never raw cpt.
//   - IDLE:
//     - start: if nxt==limit go to DONE, else go to RUN with pre=0.
//     - step: if nxt==limit go to DONE, else go to STEP.
//   - RUN:
//     - pre counts 0..div. When pre==div and nxt!=limit, drive
//       activate=1 for the next cycle and set pre=0; else activate=0.
//     - div=0 gives activate high every cycle (continuous run).
//     - nxt==limit: go to DONE, activate=0, pre=0.
//     - stop: go to IDLE, activate=0 next cycle, pre=0.
//   - STEP: activate=1 for exactly one cycle, then go to IDLE.
//     stop in STEP cancels the pending pulse; start in STEP is ignored.
//   - DONE: done=1; start and step are ignored; stop goes to IDLE.
//     A limit or cpt change while in DONE has no effect until stop.
//   - Latency: start at edge E gives busy=1 after E. The first activate
//     comes after E+div+1 edges, counting the entry edge as pre=0.
//   - Wrap: the compare is modulo 2^WIDTH. limit=0 with cpt=250 runs
//     through 255 and then 0, and halts at 0.
//   - Simultaneous start and stop always resolves to stop.
//   - div changes take effect at the next pre compare; no glitch pulse.
// TESTING
//   1. Reset held with start=1 -> activate, busy, done stay 0; IDLE
//      after release.
//   2. div=0, limit=255, cpt from 0, start pulse -> activate high every
//      cycle; cpt reaches 255, no 256th pulse, done=1.
//   3. div=3, limit=10, cpt=0, start -> pulses spaced exactly 4 clks.
//      Exactly 10 pulses; done=1 when cpt==10.
//   4. Mid-run stop with start in the same cycle -> IDLE next edge, no
//      further activate. Restart with start resumes from current cpt.
//   5. step x3 from IDLE, cpt=5, limit=7 -> two single pulses (cpt=7).
//      The third step causes no pulse and moves to DONE.
//   6. cpt=250, limit=0, div=0 -> wraps 255 to 0, halts at 0, done=1.
//      Async reset mid-run -> outputs 0 with no clk edge required.

Source files
------------

// File: rtl/cpt_run_ctrl.sv
// Run controller and prescaler driving the enable of an up-counter.
// Issues 1-clk activate pulses every div+1 clocks and halts exactly at limit.
module cpt_run_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [DIV_W-1:0] div,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] cpt,
  output logic             activate,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic             act_q, act_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] nxt;
  logic             at_limit;

  // Value the counter will hold after this edge, given the pulse now on the wire.
  assign nxt      = cpt + {{(WIDTH-1){1'b0}}, act_q};
  assign at_limit = (nxt == limit);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    act_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        pre_d = '0;
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d = at_limit ? S_DONE : S_RUN;
        end else if (step) begin
          state_d = at_limit ? S_DONE : S_STEP;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          pre_d   = '0;
        end else if (at_limit) begin
          state_d = S_DONE;
          pre_d   = '0;
        end else if (pre_q >= div) begin
          // >= so a div lowered below the running pre fires at once instead of wrapping
          act_d = 1'b1;
          pre_d = '0;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      S_STEP: begin
        state_d = S_IDLE;
        act_d   = ~stop;
      end
      S_DONE: begin
        pre_d = '0;
        if (stop) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        pre_d   = '0;
      end
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_STEP);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      act_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      act_q   <= act_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign activate = act_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
